// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game-flow controller: frame select, redraw handshake, mole timing and scoring.
// Optional difficulty ramp (shrinking mole window) is enabled by defining WHACK_DIFFICULTY_RAMP_EN.
module whack_game_ctrl #(
    parameter int MOLE_TICKS = 50_000_000,
    parameter int GAP_TICKS  = 12_500_000,
    parameter int MAX_MISSES = 3,
    parameter int SCORE_W    = 8,
    parameter int RAMP_STEP  = 2_000_000
) (
    input  logic               iClock,
    input  logic               iResetn,
    input  logic               iStartKey,
    input  logic [3:0]         iHitKey,
    input  logic               iDrawDone,
    output logic [2:0]         oState,
    output logic               oEnable,
    output logic [SCORE_W-1:0] oScore,
    output logic [1:0]         oMisses,
    output logic               oGameOver
);

    localparam int MAX_TICKS = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
    localparam int TIMER_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_TICKS - 1);
    localparam logic [TIMER_W-1:0] MOLE_LAST = TIMER_W'(MOLE_TICKS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [2:0] {
        ST_START = 3'b000,
        ST_GAME  = 3'b001,
        ST_MOLE1 = 3'b010,
        ST_MOLE2 = 3'b011,
        ST_MOLE3 = 3'b100,
        ST_MOLE4 = 3'b101,
        ST_OVER  = 3'b110
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_chg;
    logic                 r_enable;
    logic                 r_draw_wait;
    logic [TIMER_W-1:0]   r_timer;
    logic [7:0]           r_lfsr;
    logic [1:0]           r_prev_mole;
    logic                 r_start_q;
    logic [3:0]           r_hit_q;
    logic [SCORE_W-1:0]   r_score;
    logic [1:0]           r_misses;

    logic                 w_active;
    logic                 w_start_rise;
    logic [3:0]           w_hit_rise;
    logic [1:0]           w_pick;
    logic [1:0]           w_mole_idx;
    logic                 w_last_miss;
    logic                 w_changed;
    logic                 w_mole_entry;
    logic                 w_timed;
    logic                 w_lfsr_fb;
    logic [TIMER_W-1:0]   w_mole_last;
    logic                 w_hit;
    logic                 w_miss;
    logic                 w_new_game;

    assign w_active     = ~r_draw_wait;
    assign w_start_rise = iStartKey & ~r_start_q;
    assign w_hit_rise   = iHitKey & ~r_hit_q;
    assign w_pick       = (r_lfsr[1:0] == r_prev_mole) ? r_lfsr[1:0] + 2'd1 : r_lfsr[1:0];
    assign w_mole_idx   = 2'(r_state - ST_MOLE1);
    assign w_last_miss  = ({1'b0, r_misses} + 3'd1) == 3'(MAX_MISSES);
    assign w_changed    = (w_next_state != r_state);
    assign w_mole_entry = (r_state == ST_GAME) && w_changed;
    assign w_timed      = (r_state != ST_START) && (r_state != ST_OVER);
    assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

`ifdef WHACK_DIFFICULTY_RAMP_EN
    localparam longint WIN_FLOOR = longint'(MOLE_TICKS / 4);

    // Window shrinks by RAMP_STEP for every 4 hits, never below a quarter of MOLE_TICKS.
    function automatic logic [TIMER_W-1:0] f_window_last(input logic [SCORE_W-1:0] score);
        longint cut;
        longint win;
        cut = longint'(score >> 2) * longint'(RAMP_STEP);
        if (cut >= longint'(MOLE_TICKS) - WIN_FLOOR)
            win = WIN_FLOOR;
        else
            win = longint'(MOLE_TICKS) - cut;
        return TIMER_W'(win - 1);
    endfunction

    logic [TIMER_W-1:0] r_win_last;

    always_ff @(posedge iClock) begin
        if (!iResetn)
            r_win_last <= MOLE_LAST;
        else if (w_mole_entry)
            r_win_last <= f_window_last(r_score);
    end

    assign w_mole_last = r_win_last;
`else
    logic [31:0] w_unused_ramp;
    assign w_unused_ramp = 32'(RAMP_STEP);
    assign w_mole_last   = MOLE_LAST;
`endif

    always_comb begin
        w_next_state = r_state;
        w_hit        = 1'b0;
        w_miss       = 1'b0;
        w_new_game   = 1'b0;
        case (r_state)
            ST_START: begin
                if (w_active && w_start_rise) begin
                    w_next_state = ST_GAME;
                    w_new_game   = 1'b1;
                end
            end
            ST_GAME: begin
                if (w_active && (r_timer == GAP_LAST))
                    w_next_state = state_t'(3'd2 + {1'b0, w_pick});
            end
            ST_MOLE1, ST_MOLE2, ST_MOLE3, ST_MOLE4: begin
                // Correct key beats a simultaneous wrong key and the timeout.
                if (w_active) begin
                    if (w_hit_rise[w_mole_idx])
                        w_hit = 1'b1;
                    else if (|w_hit_rise)
                        w_miss = 1'b1;
                    else if (r_timer == w_mole_last)
                        w_miss = 1'b1;
                end
                if (w_hit)
                    w_next_state = ST_GAME;
                else if (w_miss)
                    w_next_state = w_last_miss ? ST_OVER : ST_GAME;
            end
            ST_OVER: begin
                if (w_active && w_start_rise)
                    w_next_state = ST_START;
            end
            default: w_next_state = ST_START;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            r_state     <= ST_START;
            r_chg       <= 1'b0;
            r_enable    <= 1'b0;
            r_draw_wait <= 1'b0;
            r_timer     <= '0;
            r_lfsr      <= 8'hA5;
            r_prev_mole <= 2'd0;
            r_start_q   <= 1'b0;
            r_hit_q     <= 4'd0;
            r_score     <= '0;
            r_misses    <= 2'd0;
        end else begin
            r_state   <= w_next_state;
            r_lfsr    <= {r_lfsr[6:0], w_lfsr_fb};
            r_start_q <= iStartKey;
            r_hit_q   <= iHitKey;
            // Redraw request trails the frame-select change by one cycle.
            r_chg     <= w_changed;
            r_enable  <= r_chg;

            if (w_changed)
                r_draw_wait <= 1'b1;
            else if (iDrawDone)
                r_draw_wait <= 1'b0;

            if (w_changed || r_draw_wait || !w_timed)
                r_timer <= '0;
            else
                r_timer <= r_timer + 1'b1;

            if (w_mole_entry)
                r_prev_mole <= w_pick;

            if (w_new_game)
                r_score <= '0;
            else if (w_hit && (r_score != SCORE_MAX))
                r_score <= r_score + 1'b1;

            if (w_new_game)
                r_misses <= 2'd0;
            else if (w_miss)
                r_misses <= r_misses + 2'd1;
        end
    end

    assign oState    = r_state;
    assign oEnable   = r_enable;
    assign oScore    = r_score;
    assign oMisses   = r_misses;
    assign oGameOver = (r_state == ST_OVER);

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Directed bench for whack_game_ctrl: table-driven start/gap phase plus hand sequences for moles,
// misses, game over, restart and mid-game reset. Drawer model answers oEnable 5 clocks later.
module tb_whack_game_ctrl;

    localparam int MOLE_TICKS = 20;
    localparam int GAP_TICKS  = 10;
    localparam int MAX_MISSES = 3;
    localparam int SCORE_W    = 8;
    localparam int RAMP_STEP  = 2;
`ifdef WHACK_DIFFICULTY_RAMP_EN
    localparam int WIN_S8  = 16;
    localparam int WIN_S40 = 5;
`else
    localparam int WIN_S8  = 20;
    localparam int WIN_S40 = 20;
`endif

    logic               iClock    = 1'b0;
    logic               iResetn   = 1'b0;
    logic               iStartKey = 1'b0;
    logic [3:0]         iHitKey   = 4'd0;
    logic               iDrawDone;
    logic [2:0]         oState;
    logic               oEnable;
    logic [SCORE_W-1:0] oScore;
    logic [1:0]         oMisses;
    logic               oGameOver;

    logic [4:0] r_dd_pipe = '0;
    logic       dd_block  = 1'b0;
    logic       dd_force  = 1'b0;

    int n_checks  = 0;
    int n_errors  = 0;
    int exp_score = 0;
    int prev_idx  = 0;

    typedef struct packed {
        logic       rstn;
        logic       start;
        logic [3:0] hit;
        logic [2:0] st;
        logic       en;
        logic [7:0] score;
        logic [1:0] miss;
        logic       over;
    } vec_t;

    whack_game_ctrl #(
        .MOLE_TICKS (MOLE_TICKS),
        .GAP_TICKS  (GAP_TICKS),
        .MAX_MISSES (MAX_MISSES),
        .SCORE_W    (SCORE_W),
        .RAMP_STEP  (RAMP_STEP)
    ) dut (
        .iClock    (iClock),
        .iResetn   (iResetn),
        .iStartKey (iStartKey),
        .iHitKey   (iHitKey),
        .iDrawDone (iDrawDone),
        .oState    (oState),
        .oEnable   (oEnable),
        .oScore    (oScore),
        .oMisses   (oMisses),
        .oGameOver (oGameOver)
    );

    always #5 iClock = ~iClock;

    always @(posedge iClock) begin
        if (!iResetn)
            r_dd_pipe <= '0;
        else
            r_dd_pipe <= {r_dd_pipe[3:0], oEnable};
    end

    assign iDrawDone = (r_dd_pipe[4] & ~dd_block) | dd_force;

    function automatic vec_t mk(input logic rstn, input logic start, input logic [3:0] hit,
                                input logic [2:0] st, input logic en);
        return '{rstn: rstn, start: start, hit: hit, st: st, en: en,
                 score: 8'd0, miss: 2'd0, over: 1'b0};
    endfunction

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_dd();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (iDrawDone)
                seen = 1'b1;
            tick();
        end
        check("draw_done_seen", int'(seen), 1);
    endtask

    task automatic wait_mole(output int m);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            tick();
            if (oState >= 3'd2 && oState <= 3'd5)
                found = 1'b1;
        end
        check("mole_entered", int'(found), 1);
        m = found ? int'(oState) - 2 : 0;
        n_checks++;
        if (m == prev_idx) begin
            n_errors++;
            $display("FAIL mole_repeat actual=%0d required=not %0d", m, prev_idx);
        end
        prev_idx = m;
    endtask

    task automatic do_hit();
        int m;
        wait_mole(m);
        wait_dd();
        iHitKey    = 4'd0;
        iHitKey[m] = 1'b1;
        tick();
        iHitKey = 4'd0;
        if (exp_score < 255)
            exp_score++;
        check("hit_score", int'(oScore), exp_score);
        check("hit_state", int'(oState), 1);
    endtask

    task automatic measure_window(input int exp_w, input int exp_miss);
        int  m;
        int  cnt;
        bit  moved;
        cnt   = 0;
        moved = 1'b0;
        wait_mole(m);
        wait_dd();
        for (int k = 1; k <= 60 && !moved; k++) begin
            tick();
            cnt = k;
            if (oState != 3'(m + 2))
                moved = 1'b1;
        end
        check("window_len", cnt, exp_w);
        check("window_misses", int'(oMisses), exp_miss);
        check("window_state", int'(oState), 1);
        check("window_score", int'(oScore), exp_score);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [19];
        int   m;

        vecs[0]  = mk(1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 4'd0, 3'd0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b1, 4'd0, 3'd1, 1'b0);
        vecs[3]  = mk(1'b1, 1'b1, 4'd0, 3'd1, 1'b1);
        vecs[4]  = mk(1'b1, 1'b0, 4'd0, 3'd1, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 4'd0, 3'd1, 1'b0);
        vecs[6]  = mk(1'b1, 1'b1, 4'd0, 3'd1, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 4'd0, 3'd1, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 4'd0, 3'd1, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 4'd0, 3'd1, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 4'd0, 3'd1, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 4'd1, 3'd1, 1'b0);
        vecs[12] = mk(1'b1, 1'b0, 4'd0, 3'd1, 1'b0);
        vecs[13] = mk(1'b1, 1'b1, 4'd0, 3'd1, 1'b0);
        vecs[14] = mk(1'b1, 1'b0, 4'd0, 3'd1, 1'b0);
        vecs[15] = mk(1'b1, 1'b0, 4'd0, 3'd1, 1'b0);
        vecs[16] = mk(1'b1, 1'b0, 4'd0, 3'd1, 1'b0);
        vecs[17] = mk(1'b1, 1'b0, 4'd0, 3'd1, 1'b0);
        vecs[18] = mk(1'b1, 1'b0, 4'd0, 3'd1, 1'b0);

        // Reset, start, and the full gap before the first mole
        for (int i = 0; i < 19; i++) begin
            iResetn   = vecs[i].rstn;
            iStartKey = vecs[i].start;
            iHitKey   = vecs[i].hit;
            tick();
            check($sformatf("vec%0d_state", i), int'(oState), int'(vecs[i].st));
            check($sformatf("vec%0d_enable", i), int'(oEnable), int'(vecs[i].en));
            check($sformatf("vec%0d_score", i), int'(oScore), int'(vecs[i].score));
            check($sformatf("vec%0d_misses", i), int'(oMisses), int'(vecs[i].miss));
            check($sformatf("vec%0d_over", i), int'(oGameOver), int'(vecs[i].over));
        end
        iHitKey   = 4'd0;
        iStartKey = 1'b0;

        // First mole: exact entry edge, redraw pulse, hit 3 cycles after draw done
        wait_mole(m);
        check("mole_entry_edge", int'(oState), m + 2);
        check("mole_enable_lag", int'(oEnable), 0);
        tick();
        check("mole_enable", int'(oEnable), 1);
        tick();
        check("mole_enable_pulse", int'(oEnable), 0);
        wait_dd();
        tick();
        tick();
        iHitKey[m] = 1'b1;
        tick();
        iHitKey   = 4'd0;
        exp_score = 1;
        check("first_hit_score", int'(oScore), 1);
        check("first_hit_state", int'(oState), 1);

        // Key pressed during draw_wait and held through draw done is never a hit
        wait_mole(m);
        iHitKey[m] = 1'b1;
        tick();
        check("drawwait_key_state", int'(oState), m + 2);
        wait_dd();
        tick();
        check("held_key_state", int'(oState), m + 2);
        check("held_key_score", int'(oScore), 1);
        iHitKey = 4'd0;
        tick();
        iHitKey[m]           = 1'b1;
        iHitKey[(m + 1) % 4] = 1'b1;
        tick();
        iHitKey   = 4'd0;
        exp_score = 2;
        check("dual_key_score", int'(oScore), 2);
        check("dual_key_state", int'(oState), 1);
        check("dual_key_misses", int'(oMisses), 0);

        // Key held 50 clocks counts once; no gap progress without draw done
        wait_mole(m);
        wait_dd();
        iHitKey[m] = 1'b1;
        dd_block   = 1'b1;
        tick();
        exp_score = 3;
        check("hold_hit_score", int'(oScore), 3);
        repeat (50) tick();
        check("hold_once_score", int'(oScore), 3);
        check("hold_once_misses", int'(oMisses), 0);
        check("no_draw_done_state", int'(oState), 1);
        iHitKey  = 4'd0;
        dd_block = 1'b0;
        tick();
        dd_force = 1'b1;
        tick();
        dd_force = 1'b0;

        // Window length at score 8 and score 40, each ending in a timeout miss
        repeat (5) do_hit();
        measure_window(WIN_S8, 1);
        repeat (32) do_hit();
        measure_window(WIN_S40, 2);

        // Third miss by wrong key ends the game
        wait_mole(m);
        wait_dd();
        iHitKey[(m + 2) % 4] = 1'b1;
        tick();
        iHitKey = 4'd0;
        check("over_state", int'(oState), 6);
        check("over_flag", int'(oGameOver), 1);
        check("over_misses", int'(oMisses), 3);
        check("over_score", int'(oScore), 40);
        tick();
        check("over_enable", int'(oEnable), 1);
        wait_dd();
        iHitKey = 4'hF;
        tick();
        iHitKey = 4'd0;
        tick();
        check("frozen_score", int'(oScore), 40);
        check("frozen_misses", int'(oMisses), 3);
        check("frozen_state", int'(oState), 6);
        iStartKey = 1'b1;
        tick();
        iStartKey = 1'b0;
        check("restart_state", int'(oState), 0);
        check("restart_over_flag", int'(oGameOver), 0);
        check("restart_score_kept", int'(oScore), 40);
        wait_dd();
        iStartKey = 1'b1;
        tick();
        iStartKey = 1'b0;
        exp_score = 0;
        check("newgame_state", int'(oState), 1);
        check("newgame_score", int'(oScore), 0);
        check("newgame_misses", int'(oMisses), 0);

        // Reset in the middle of a mole aborts the game at once
        repeat (5) do_hit();
        wait_mole(m);
        wait_dd();
        tick();
        check("prereset_score", int'(oScore), 5);
        check("prereset_state", int'(oState), m + 2);
        iResetn = 1'b0;
        tick();
        check("reset_state", int'(oState), 0);
        check("reset_score", int'(oScore), 0);
        check("reset_misses", int'(oMisses), 0);
        check("reset_enable", int'(oEnable), 0);
        check("reset_over", int'(oGameOver), 0);
        iResetn = 1'b1;
        tick();
        check("postreset_state", int'(oState), 0);
        check("postreset_enable", int'(oEnable), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
